hoene_smart_led_io: RTL and testbench

- Front-end and back-end of the smart-LED pixel.
- Picks one of two redundant serial line inputs (upstream/alternate daisy-chain port) and forwards it, synchronized, to the decoder chain.
- Drives three 10-bit PWM outputs for the red/green/blue LED channels.
- The decoder/protocol logic between the two halves lives in other blocks.

---
 rtl/hoene_smart_led_io_pkg.sv | 16 +
 rtl/hoene_line_select.sv | 87 ++++++++
 rtl/hoene_pwm_cell.sv | 38 +++
 rtl/hoene_smart_led_io.sv | 83 ++++++++
 tb/tb_hoene_smart_led_io.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/hoene_smart_led_io_pkg.sv
// Shared constants and types for the smart-LED pixel I/O block.
//   PWM_BITS_DEF : default PWM data / counter width
//   PWM_PERIOD   : clocks per PWM period (2^PWM_BITS_DEF - 1)
//   sel_state_t  : line-selection FSM state encoding
package hoene_smart_led_io_pkg;

  localparam int PWM_BITS_DEF = 10;
  localparam int PWM_PERIOD   = (1 << PWM_BITS_DEF) - 1;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_0    = 2'd1,
    SEL_1    = 2'd2
  } sel_state_t;

endpackage

// File: rtl/hoene_line_select.sv
// Redundant serial-line front end: synchronizes both line inputs, locks onto
// whichever shows the first rising edge, and forwards it registered.
//   clk, rst     : system clock, async active-high reset
//   in0, in1     : asynchronous primary / alternate line inputs
//   testmode     : forces the in0 path
//   out          : synchronized, registered selected line
//   in0selected  : 1 while the in0 path is active
//
// state    | meaning
// ---------+-------------------------------------------
// SEL_NONE | no line seen yet, out held at 0
// SEL_0    | locked to in0 until reset
// SEL_1    | locked to in1 until reset
module hoene_line_select
  import hoene_smart_led_io_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in0,
  input  logic in1,
  input  logic testmode,
  output logic out,
  output logic in0selected
);

  logic [SYNC_STAGES-1:0] sync0;
  logic [SYNC_STAGES-1:0] sync1;
  logic                   s0;
  logic                   s1;
  logic                   s0_d;
  logic                   s1_d;
  logic                   rise0;
  logic                   rise1;
  logic                   use0;
  logic                   line_nxt;
  sel_state_t             state;
  sel_state_t             state_nxt;

  assign s0    = sync0[SYNC_STAGES-1];
  assign s1    = sync1[SYNC_STAGES-1];
  assign rise0 = s0 & ~s0_d;
  assign rise1 = s1 & ~s1_d;

  always_comb begin
    state_nxt = state;
    case (state)
      SEL_NONE: begin
        // in0 has priority when both lines rise in the same cycle
        if (rise0)      state_nxt = SEL_0;
        else if (rise1) state_nxt = SEL_1;
      end
      default: ;
    endcase
  end

  // The mux looks at the next state so the edge that causes the lock is
  // itself passed through rather than swallowed.
  always_comb begin
    use0 = testmode | (state_nxt == SEL_0);
    if (use0)                       line_nxt = s0;
    else if (state_nxt == SEL_1)    line_nxt = s1;
    else                            line_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0 <= '0;
      sync1 <= '0;
      s0_d  <= 1'b0;
      s1_d  <= 1'b0;
      state <= SEL_NONE;
      out   <= 1'b0;
    end else begin
      sync0 <= {sync0[SYNC_STAGES-2:0], in0};
      sync1 <= {sync1[SYNC_STAGES-2:0], in1};
      s0_d  <= s0;
      s1_d  <= s1;
      state <= state_nxt;
      out   <= line_nxt;
    end
  end

  assign in0selected = testmode | (state == SEL_0);

endmodule

// File: rtl/hoene_pwm_cell.sv
// One PWM channel: shadow register plus registered compare against the
// shared period counter.
//   clk, rst : system clock, async active-high reset
//   load     : period start (counter at 0); shadow takes new data
//   cnt      : shared period counter
//   data     : requested duty value
//   pwm      : registered PWM output
module hoene_pwm_cell
  import hoene_smart_led_io_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [PWM_BITS-1:0] cnt,
  input  logic [PWM_BITS-1:0] data,
  output logic                pwm
);

  logic [PWM_BITS-1:0] shadow;
  logic [PWM_BITS-1:0] duty;

  // At period start the compare already uses the freshly captured value,
  // so a duty of N gives exactly N high clocks from the period start.
  assign duty = load ? data : shadow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      pwm    <= 1'b0;
    end else begin
      shadow <= duty;
      pwm    <= (duty > cnt);
    end
  end

endmodule

// File: rtl/hoene_smart_led_io.sv
// Smart-LED pixel I/O: redundant line input selection on the front end and
// three RGB PWM drivers sharing one period counter on the back end.
//   clk                 : system clock
//   rst_n               : async reset, active-HIGH despite the name
//   in0, in1            : asynchronous serial line inputs
//   testmode            : force in0 selection
//   data_red/green/blue : PWM duty values
//   out                 : synchronized selected line
//   in0selected         : in0 path active
//   out_red/green/blue  : PWM outputs
module hoene_smart_led_io
  import hoene_smart_led_io_pkg::*;
#(
  parameter int PWM_BITS    = PWM_BITS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in0,
  input  logic                in1,
  input  logic                testmode,
  input  logic [PWM_BITS-1:0] data_red,
  input  logic [PWM_BITS-1:0] data_green,
  input  logic [PWM_BITS-1:0] data_blue,
  output logic                out,
  output logic                in0selected,
  output logic                out_red,
  output logic                out_green,
  output logic                out_blue
);

  // Counter runs 0..2^PWM_BITS-2 so a full-scale duty stays constantly high.
  localparam logic [PWM_BITS-1:0] CNT_MAX = {{(PWM_BITS-1){1'b1}}, 1'b0};

  logic [PWM_BITS-1:0] cnt;
  logic                load;

  assign load = (cnt == '0);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)               cnt <= '0;
    else if (cnt == CNT_MAX) cnt <= '0;
    else                     cnt <= cnt + 1'b1;
  end

  hoene_line_select #(.SYNC_STAGES(SYNC_STAGES)) u_line_select (
    .clk         (clk),
    .rst         (rst_n),
    .in0         (in0),
    .in1         (in1),
    .testmode    (testmode),
    .out         (out),
    .in0selected (in0selected)
  );

  hoene_pwm_cell #(.PWM_BITS(PWM_BITS)) u_pwm_red (
    .clk  (clk),
    .rst  (rst_n),
    .load (load),
    .cnt  (cnt),
    .data (data_red),
    .pwm  (out_red)
  );

  hoene_pwm_cell #(.PWM_BITS(PWM_BITS)) u_pwm_green (
    .clk  (clk),
    .rst  (rst_n),
    .load (load),
    .cnt  (cnt),
    .data (data_green),
    .pwm  (out_green)
  );

  hoene_pwm_cell #(.PWM_BITS(PWM_BITS)) u_pwm_blue (
    .clk  (clk),
    .rst  (rst_n),
    .load (load),
    .cnt  (cnt),
    .data (data_blue),
    .pwm  (out_blue)
  );

endmodule

// File: tb/tb_hoene_smart_led_io.sv
// Directed bench for hoene_smart_led_io: line selection, latency, testmode
// override, PWM duty counts, shadow timing and mid-period reset.
module tb_hoene_smart_led_io;

  logic       clk;
  logic       rst_n;
  logic       in0;
  logic       in1;
  logic       testmode;
  logic [9:0] data_red;
  logic [9:0] data_green;
  logic [9:0] data_blue;
  logic       out;
  logic       in0selected;
  logic       out_red;
  logic       out_green;
  logic       out_blue;

  int n_checks;
  int n_pass;

  hoene_smart_led_io dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in0         (in0),
    .in1         (in1),
    .testmode    (testmode),
    .data_red    (data_red),
    .data_green  (data_green),
    .data_blue   (data_blue),
    .out         (out),
    .in0selected (in0selected),
    .out_red     (out_red),
    .out_green   (out_green),
    .out_blue    (out_blue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset is released on a falling edge, so the next rising edge is the
  // first active cycle (counter at 0).
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic run_count(input int n, output int r, output int g, output int b);
    r = 0; g = 0; b = 0;
    for (int i = 0; i < n; i++) begin
      tick(1);
      r += int'(out_red);
      g += int'(out_green);
      b += int'(out_blue);
    end
  endtask

  int r, g, b, r2, g2, b2;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0; in0 = 1'b0; in1 = 1'b0; testmode = 1'b0;
    data_red = '0; data_green = '0; data_blue = '0;
    #1 rst_n = 1'b1;
    #20;
    check("rst_out",         int'(out), 0);
    check("rst_in0selected", int'(in0selected), 0);
    check("rst_red",         int'(out_red), 0);
    check("rst_green",       int'(out_green), 0);
    check("rst_blue",        int'(out_blue), 0);
    @(negedge clk);
    rst_n = 1'b0;
    run_count(3000, r, g, b);
    check("zero_red",   r, 0);
    check("zero_green", g, 0);
    check("zero_blue",  b, 0);

    // in1 first: SEL1, latency SYNC_STAGES+1
    do_reset();
    tick(10);
    in1 = 1'b1;
    tick(2);
    check("in1_lat_before", int'(out), 0);
    tick(1);
    check("in1_lat_at", int'(out), 1);
    check("in1_in0selected", int'(in0selected), 0);
    in1 = 1'b0;
    tick(2);
    check("in1_fall_before", int'(out), 1);
    tick(1);
    check("in1_fall_at", int'(out), 0);
    for (int i = 0; i < 6; i++) begin
      in0 = ~in0;
      tick(2);
      check("in1_ignore_in0", int'(out), 0);
    end
    check("in1_sticky", int'(in0selected), 0);
    in0 = 1'b0;
    in1 = 1'b1;
    tick(3);
    check("in1_follow_again", int'(out), 1);
    in1 = 1'b0;

    // simultaneous edges: in0 wins
    do_reset();
    tick(5);
    in0 = 1'b1; in1 = 1'b1;
    tick(3);
    check("sim_in0selected", int'(in0selected), 1);
    check("sim_out", int'(out), 1);
    in0 = 1'b0;
    tick(3);
    check("sim_follow_in0", int'(out), 0);
    in1 = 1'b0;

    // testmode override after in1 selection
    do_reset();
    tick(5);
    in1 = 1'b1;
    tick(3);
    in0 = 1'b1; in1 = 1'b0;
    tick(4);
    check("tm_off_out", int'(out), 0);
    check("tm_off_in0selected", int'(in0selected), 0);
    testmode = 1'b1;
    #1;
    check("tm_on_in0selected", int'(in0selected), 1);
    tick(1);
    check("tm_on_out", int'(out), 1);
    in0 = 1'b0;
    tick(3);
    check("tm_follow_in0", int'(out), 0);
    testmode = 1'b0;

    // duty 512 / 0 / 1023
    data_red = 10'd512; data_green = 10'd0; data_blue = 10'd1023;
    do_reset();
    run_count(1023, r, g, b);
    check("duty_red",   r, 512);
    check("duty_green", g, 0);
    check("duty_blue",  b, 1023);
    run_count(1023, r, g, b);
    check("duty_red_p2",  r, 512);
    check("duty_blue_p2", b, 1023);

    // mid-period change only takes effect next period
    data_red = 10'd0; data_blue = 10'd0; data_green = 10'd100;
    do_reset();
    run_count(500, r, g, b);
    data_green = 10'd900;
    run_count(523, r2, g2, b2);
    check("shadow_cur",  g + g2, 100);
    run_count(1023, r, g, b);
    check("shadow_next", g, 900);

    // async reset mid-period
    data_red = 10'd1023; data_green = 10'd0;
    do_reset();
    tick(300);
    check("mid_red_high", int'(out_red), 1);
    rst_n = 1'b1;
    #1;
    check("mid_red_async_low", int'(out_red), 0);
    @(negedge clk);
    check("mid_red_held_low", int'(out_red), 0);
    rst_n = 1'b0;
    tick(1);
    check("mid_red_first_cycle", int'(out_red), 1);
    run_count(1022, r, g, b);
    check("mid_red_period", r + 1, 1023);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
